mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (address0/ad0/ce0/we0/q0 convention) among
//  NUM_REQ FSM-sequenced kernels. Each kernel drives its own port-shaped request. The
//  arbiter grants round-robin, performs one access per grant, returns read data and pulses
//  an ack. It sits between kernel memory ports and the shared array instance.
// PARAMETERS
//  NUM_REQ  2   number of requester ports (>=2)
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  RD_LAT   2   cycles from mem_ce0 sampled high to mem_q0 valid (>=1)
// PORTS
//  ap_clk        in   1               clock, all state on rising edge
//  ap_rst_n      in   1               reset, asynchronous, active-low
//  req_address0  in   NUM_REQ*ADDR_W  per-requester address, slice i = requester i
//  req_ad0       in   NUM_REQ*DATA_W  per-requester write data
//  req_ce0       in   NUM_REQ         read request (level, held until ack)
//  req_we0       in   NUM_REQ         write request (level, held until ack)
//  req_q0        out  NUM_REQ*DATA_W  per-requester read data, registered, held
//  req_ack       out  NUM_REQ         1-cycle completion pulse to the granted requester
//  mem_address0  out  ADDR_W          shared RAM address
//  mem_ad0       out  DATA_W          shared RAM write data
//  mem_ce0       out  1               shared RAM read enable
//  mem_we0       out  1               shared RAM write enable
//  mem_q0        in   DATA_W          shared RAM read data
//  busy          out  1               high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, req_q0 all 0, rr pointer 0, FSM IDLE; reset mid-access aborts the
//   access, no ack is issued, and mem_ce0/mem_we0 drop asynchronously.
//  Request i = req_ce0[i] | req_we0[i]. If both bits are set, the request is a write.
//  FSM IDLE -> GRANT -> (WRITE | READ -> WAIT) -> ACK -> IDLE:
//   IDLE : if any request, pick first active i searching from rr upward (mod NUM_REQ);
//          latch i, address, data, and kind into grant registers; go GRANT.
//   GRANT: drive latched address; write -> mem_we0=1, mem_ad0=data, go ACK;
//          read -> mem_ce0=1, go WAIT. Exactly one cycle of ce/we per access.
//   WAIT : count RD_LAT-1 cycles; in the cycle mem_q0 is valid, capture into req_q0[i]; go ACK.
//   ACK  : req_ack[i]=1 for one cycle; rr <= (i+1) mod NUM_REQ; go IDLE.
//  Latency from request in IDLE to ack: write 3 cycles, read 3+RD_LAT-1 cycles.
//  Requesters drop the request in the cycle after seeing ack. A still-held request
//   re-arbitrates in IDLE as a new access.
//  A request dropped after latch does not cancel the access; the ack still pulses.
//  Inputs of non-granted requesters are ignored. Request changes after latch are ignored.
//  req_q0[j] changes only on a completed read for j.
//  mem_address0/mem_ad0 hold their last value outside GRANT.
//  rr wraps from NUM_REQ-1 to 0. Worst-case wait: NUM_REQ-1 other accesses.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, GRANT, WRITE, READ, WAIT, ACK as one-hot constants)
//   and the ACC_RD/ACC_WR access-kind constant.
//  Sub-module rr_pick: combinational round-robin selector (req vector, rr ptr -> index, valid).
//  Top: FSM, grant registers, latency counter, req_q0 register bank.
// TESTING
//  1 Single read: RAM[5]=0x1234, req_ce0[0]=1 addr 5 -> mem_ce0 one cycle; ack[0] 4 cycles
//    after request (RD_LAT=2); req_q0[0]=0x1234.
//  2 Single write: req_we0[1]=1 addr 7 data 0xAA -> one mem_we0 pulse, addr 7, ad 0xAA; ack[1]
//    at cycle 3; readback 0xAA.
//  3 Contention: both request from reset -> grant order 0,1,0,1 over 4 held accesses;
//    no two ce/we cycles overlap.
//  4 ce&we both set on requester 0 -> treated as write; mem_ce0 stays 0.
//  5 Request dropped during WAIT -> ack still pulses; req_q0 updated; next grant goes to the other
//    requester.
//  6 ap_rst_n low during WAIT -> outputs 0 immediately, no ack. After release, the held request
//    is served from rr=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state codes,
// access-kind encoding and the round-robin pointer step.
package mem_port_arbiter_pkg;

  // state  | meaning
  // IDLE   | no access in flight, arbitrate among active requests
  // GRANT  | latched address on the RAM port, one cycle of ce0 or we0
  // WRITE  | write-access code, available to decoders of the state value
  // READ   | read-access code, available to decoders of the state value
  // WAIT   | read data in flight, count down to the cycle mem_q0 is valid
  // ACK    | completion pulse to the granted requester, advance rr
  // GRANT issues the write or read strobe itself, so the FSM never sits in
  // WRITE or READ.
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_GRANT = 6'b000010,
    ST_WRITE = 6'b000100,
    ST_READ  = 6'b001000,
    ST_WAIT  = 6'b010000,
    ST_ACK   = 6'b100000
  } state_t;

  typedef enum logic {
    ACC_RD = 1'b0,
    ACC_WR = 1'b1
  } acc_t;

  // Next round-robin pointer after serving idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request at or above rr,
// wrapping modulo NUM_REQ.
module mem_port_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] j;

  // Scan from the farthest candidate down so the nearest one to rr wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDX_W'((int'(rr) + k) % NUM_REQ);
      if (req[j]) begin
        idx   = j;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among
// NUM_REQ kernel memory ports; one access per grant, ack on completion.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 2
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address0,
  input  logic [NUM_REQ*DATA_W-1:0] req_ad0,
  input  logic [NUM_REQ-1:0]        req_ce0,
  input  logic [NUM_REQ-1:0]        req_we0,
  output logic [NUM_REQ*DATA_W-1:0] req_q0,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [ADDR_W-1:0]         mem_address0,
  output logic [DATA_W-1:0]         mem_ad0,
  output logic                      mem_ce0,
  output logic                      mem_we0,
  input  logic [DATA_W-1:0]         mem_q0,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  // WAIT lasts RD_LAT-1 cycles; the counter holds the cycles left after this one.
  localparam logic [CNT_W-1:0] WAIT_LOAD = (RD_LAT >= 2) ? CNT_W'(RD_LAT - 2) : '0;

  state_t             state;
  acc_t               gnt_kind;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   rr;
  logic [CNT_W-1:0]   wait_cnt;

  logic [NUM_REQ-1:0] req_vec;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_wr;
  logic [NUM_REQ-1:0] ack_vec;

  assign req_vec = req_ce0 | req_we0;
  assign ack_vec = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;

  mem_port_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req_vec),
    .rr    (rr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Route the picked requester's address, data and kind; we0 wins over ce0.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_wr   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr = req_address0[i*ADDR_W +: ADDR_W];
        sel_data = req_ad0[i*DATA_W +: DATA_W];
        sel_wr   = req_we0[i];
      end
    end
  end

  // Access sequencer: grant registers, RAM strobes, read capture and ack.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= ST_IDLE;
      gnt_kind     <= ACC_RD;
      gnt_idx      <= '0;
      rr           <= '0;
      wait_cnt     <= '0;
      req_q0       <= '0;
      req_ack      <= '0;
      mem_address0 <= '0;
      mem_ad0      <= '0;
      mem_ce0      <= 1'b0;
      mem_we0      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_idx      <= pick_idx;
            gnt_kind     <= sel_wr ? ACC_WR : ACC_RD;
            mem_address0 <= sel_addr;
            if (sel_wr) begin
              mem_ad0 <= sel_data;
              mem_we0 <= 1'b1;
            end else begin
              mem_ce0 <= 1'b1;
            end
            busy  <= 1'b1;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          mem_ce0 <= 1'b0;
          mem_we0 <= 1'b0;
          if (gnt_kind == ACC_WR) begin
            req_ack <= ack_vec;
            state   <= ST_ACK;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
              if (gnt_idx == IDX_W'(i)) begin
                req_q0[i*DATA_W +: DATA_W] <= mem_q0;
              end
            end
            req_ack <= ack_vec;
            state   <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ACK: begin
          rr    <= IDX_W'(rr_next(int'(gnt_idx), NUM_REQ));
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          mem_ce0 <= 1'b0;
          mem_we0 <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two requesters, RD_LAT=2 RAM model.
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 2;

  logic             ap_clk;
  logic             ap_rst_n;
  logic [NR*AW-1:0] req_address0;
  logic [NR*DW-1:0] req_ad0;
  logic [NR-1:0]    req_ce0;
  logic [NR-1:0]    req_we0;
  logic [NR*DW-1:0] req_q0;
  logic [NR-1:0]    req_ack;
  logic [AW-1:0]    mem_address0;
  logic [DW-1:0]    mem_ad0;
  logic             mem_ce0;
  logic             mem_we0;
  logic [DW-1:0]    mem_q0;
  logic             busy;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .req_address0 (req_address0),
    .req_ad0      (req_ad0),
    .req_ce0      (req_ce0),
    .req_we0      (req_we0),
    .req_q0       (req_q0),
    .req_ack      (req_ack),
    .mem_address0 (mem_address0),
    .mem_ad0      (mem_ad0),
    .mem_ce0      (mem_ce0),
    .mem_we0      (mem_we0),
    .mem_q0       (mem_q0),
    .busy         (busy)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int cyc = 0;
  initial forever @(posedge ap_clk) cyc <= cyc + 1;

  // RAM model: one output register, so q0 is valid the cycle after ce0.
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] q_reg;
  logic          bd_we = 1'b0;
  logic [7:0]    bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge ap_clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we0) ram[mem_address0[7:0]] <= mem_ad0;
    if (mem_ce0) q_reg <= ram[mem_address0[7:0]];
  end
  assign mem_q0 = q_reg;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic we; logic [31:0] addr; logic [31:0] ad; } acc_e;
  typedef struct { int port; logic rd; logic [31:0] q; int c; } ack_e;
  acc_e acc_q[$];
  ack_e ack_q[$];

  task automatic exp_acc(input logic we, input logic [31:0] addr, input logic [31:0] ad);
    acc_e e;
    e.we = we; e.addr = addr; e.ad = ad;
    acc_q.push_back(e);
  endtask

  task automatic exp_ack(input int port, input logic rd, input logic [31:0] q, input int c);
    ack_e e;
    e.port = port; e.rd = rd; e.q = q; e.c = c;
    ack_q.push_back(e);
  endtask

  // Monitor: pops the expected access on every RAM strobe and the expected
  // completion on every ack.
  initial begin
    acc_e a;
    ack_e k;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n) begin
        if (mem_ce0 && mem_we0) check("ce_we_overlap", 64'(mem_ce0 & mem_we0), 64'd0);
        if (mem_ce0 || mem_we0) begin
          if (acc_q.size() == 0) begin
            check("unexpected_access", 64'(mem_address0), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            a = acc_q.pop_front();
            check("acc_we", 64'(mem_we0), 64'(a.we));
            check("acc_ce", 64'(mem_ce0), 64'(!a.we));
            check("acc_addr", 64'(mem_address0), 64'(a.addr));
            if (a.we) check("acc_ad", 64'(mem_ad0), 64'(a.ad));
          end
        end
        if (req_ack != '0) begin
          if (ack_q.size() == 0) begin
            check("unexpected_ack", 64'(req_ack), 64'd0);
          end else begin
            k = ack_q.pop_front();
            check("ack_port", 64'(req_ack), 64'(2'b01 << k.port));
            if (k.rd) check("rd_data", 64'(k.port == 1 ? req_q0[63:32] : req_q0[31:0]), 64'(k.q));
            if (k.c >= 0) check("ack_latency", 64'(cyc), 64'(k.c));
          end
        end
      end
    end
  end

  // Requester agent: holds each request until the issued count is served,
  // dropping it in the cycle after the ack.
  logic        a_ce   [NR];
  logic        a_we   [NR];
  logic [31:0] a_addr [NR];
  logic [31:0] a_data [NR];
  int          issued [NR];
  int          served [NR];
  logic        drop   [NR];

  initial begin
    logic [NR-1:0] ack_s;
    for (int i = 0; i < NR; i++) begin
      a_ce[i] = 0; a_we[i] = 0; a_addr[i] = 0; a_data[i] = 0;
      issued[i] = 0; served[i] = 0; drop[i] = 0;
    end
  end

  initial begin
    logic [NR-1:0] ack_s;
    req_ce0 = '0; req_we0 = '0; req_address0 = '0; req_ad0 = '0;
    forever begin
      @(negedge ap_clk);
      ack_s = req_ack;
      @(posedge ap_clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (ack_s[i]) served[i]++;
        req_ce0[i] = (issued[i] != served[i]) && !drop[i] && a_ce[i];
        req_we0[i] = (issued[i] != served[i]) && !drop[i] && a_we[i];
        req_address0[i*AW +: AW] = a_addr[i];
        req_ad0[i*DW +: DW] = a_data[i];
      end
    end
  end

  task automatic issue(input int p, input logic ce, input logic we,
                       input logic [31:0] addr, input logic [31:0] data, input int cnt);
    a_ce[p] = ce; a_we[p] = we; a_addr[p] = addr; a_data[p] = data;
    issued[p] += cnt;
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge ap_clk);
      #3;
      done = (acc_q.size() == 0) && (ack_q.size() == 0) &&
             (issued[0] == served[0]) && (issued[1] == served[1]);
    end
    if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic bd_write(input logic [7:0] addr, input logic [31:0] data);
    @(negedge ap_clk);
    bd_we = 1'b1; bd_addr = addr; bd_data = data;
    @(negedge ap_clk);
    bd_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce0"},  64'(mem_ce0), 64'd0);
    check({tag, "_we0"},  64'(mem_we0), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ack"},  64'(req_ack), 64'd0);
    check({tag, "_q0"},   64'(req_q0), 64'd0);
    check({tag, "_addr"}, 64'(mem_address0), 64'd0);
    check({tag, "_ad0"},  64'(mem_ad0), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    check_reset_outputs("reset");
    bd_write(8'h05, 32'h0000_1234);
    bd_write(8'h09, 32'h0000_5555);
    bd_write(8'h20, 32'h0000_CAFE);
    bd_write(8'h21, 32'h0000_BEEF);
    ap_rst_n = 1'b1;
    repeat (2) step();

    // 1: single read, RD_LAT=2 -> ack in cycle 4 counting the request cycle as 1
    step(); t = cyc;
    issue(0, 1'b1, 1'b0, 32'd5, 32'd0, 1);
    exp_acc(1'b0, 32'd5, 32'd0);
    exp_ack(0, 1'b1, 32'h1234, t + 3);
    wait_done("t1");
    check("t1_q0", 64'(req_q0[31:0]), 64'h1234);

    // 2: single write from requester 1, ack in cycle 3, then readback
    step(); t = cyc;
    issue(1, 1'b0, 1'b1, 32'd7, 32'hAA, 1);
    exp_acc(1'b1, 32'd7, 32'hAA);
    exp_ack(1, 1'b0, 32'd0, t + 2);
    wait_done("t2w");
    step(); t = cyc;
    issue(1, 1'b1, 1'b0, 32'd7, 32'd0, 1);
    exp_acc(1'b0, 32'd7, 32'd0);
    exp_ack(1, 1'b1, 32'hAA, t + 3);
    wait_done("t2r");
    check("t2_q0_other_held", 64'(req_q0[31:0]), 64'h1234);
    check("t2_idle_busy", 64'(busy), 64'd0);

    // 3: contention from reset, two held accesses each -> 0,1,0,1
    do_reset();
    step();
    check("t3_q0_cleared", 64'(req_q0), 64'd0);
    issue(0, 1'b1, 1'b0, 32'h20, 32'd0, 2);
    issue(1, 1'b0, 1'b1, 32'h40, 32'h77, 2);
    exp_acc(1'b0, 32'h20, 32'd0);
    exp_acc(1'b1, 32'h40, 32'h77);
    exp_acc(1'b0, 32'h20, 32'd0);
    exp_acc(1'b1, 32'h40, 32'h77);
    exp_ack(0, 1'b1, 32'hCAFE, -1);
    exp_ack(1, 1'b0, 32'd0, -1);
    exp_ack(0, 1'b1, 32'hCAFE, -1);
    exp_ack(1, 1'b0, 32'd0, -1);
    wait_done("t3");

    // 4: ce and we together on requester 0 is a write; readback via requester 1
    step(); t = cyc;
    issue(0, 1'b1, 1'b1, 32'h50, 32'h99, 1);
    exp_acc(1'b1, 32'h50, 32'h99);
    exp_ack(0, 1'b0, 32'd0, t + 2);
    wait_done("t4w");
    step();
    issue(1, 1'b1, 1'b0, 32'h50, 32'd0, 1);
    exp_acc(1'b0, 32'h50, 32'd0);
    exp_ack(1, 1'b1, 32'h99, -1);
    wait_done("t4r");

    // 5: request dropped during WAIT still completes; rr moves to requester 1
    step(); t = cyc;
    issue(0, 1'b1, 1'b0, 32'd9, 32'd0, 1);
    exp_acc(1'b0, 32'd9, 32'd0);
    exp_ack(0, 1'b1, 32'h5555, t + 3);
    step();
    step();
    drop[0] = 1'b1;
    check("t5_busy_wait", 64'(busy), 64'd1);
    wait_done("t5a");
    drop[0] = 1'b0;
    step();
    issue(0, 1'b1, 1'b0, 32'd5, 32'd0, 1);
    issue(1, 1'b1, 1'b0, 32'h21, 32'd0, 1);
    exp_acc(1'b0, 32'h21, 32'd0);
    exp_acc(1'b0, 32'd5, 32'd0);
    exp_ack(1, 1'b1, 32'hBEEF, -1);
    exp_ack(0, 1'b1, 32'h1234, -1);
    wait_done("t5b");

    // 6: reset during WAIT aborts silently; held requests restart from rr=0
    step();
    issue(1, 1'b1, 1'b0, 32'h21, 32'd0, 1);
    issue(0, 1'b1, 1'b0, 32'd5, 32'd0, 1);
    exp_acc(1'b0, 32'h21, 32'd0);
    step();
    step();
    check("t6_busy_wait", 64'(busy), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    exp_acc(1'b0, 32'd5, 32'd0);
    exp_acc(1'b0, 32'h21, 32'd0);
    exp_ack(0, 1'b1, 32'h1234, -1);
    exp_ack(1, 1'b1, 32'hBEEF, -1);
    repeat (2) @(negedge ap_clk);
    check("t6_no_ack_in_reset", 64'(req_ack), 64'd0);
    ap_rst_n = 1'b1;
    wait_done("t6");
    check("t6_q0", 64'(req_q0), {32'hBEEF, 32'h1234});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
